// File: rtl/mont_mult_serial.sv
`default_nettype none
// ============================================================================
// Module      : mont_mult_serial
// Description : Bit-serial Montgomery modular multiplier.
//               Computes result = A * B * 2^-WIDTH mod M. Operand A arrives
//               one bit per cycle, LSB first, from the shift register that
//               sits upstream. This block drives that register's load/shift
//               control. The latency is fixed and data-independent:
//               WIDTH RUN cycles followed by one FIN cycle.
//
// Ports       : clk        - system clock, rising-edge active
//               reset      - asynchronous reset, active low
//               start      - start request, only sampled in IDLE
//               a_bit      - current LSB of A (shift register shift_out)
//               b_in       - operand B, latched when start is accepted
//               m_in       - modulus M (odd), latched when start is accepted
//               load_shift - 0 = shift register loads A, 1 = shift right
//               busy       - high in RUN and FIN
//               done       - one-cycle pulse, result valid
//               result     - Montgomery product, held until the next done
//
// Revision    : 1.0 - initial release
// ============================================================================
module mont_mult_serial #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             a_bit,
   input  logic [WIDTH-1:0] b_in,
   input  logic [WIDTH-1:0] m_in,
   output logic             load_shift,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [WIDTH+1:0]   r_s;
   logic [c_CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_m;
   logic               r_done;
   logic [WIDTH-1:0]   r_result;

   logic [WIDTH+1:0]   w_b_ext;
   logic [WIDTH+1:0]   w_m_ext;
   logic [WIDTH+1:0]   w_t;
   logic [WIDTH+1:0]   w_u;
   logic [WIDTH+1:0]   w_s_nxt;
   logic [WIDTH+1:0]   w_red;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and state-decoded outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      load_shift  = 1'b0;
      busy        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            load_shift = 1'b1;
            busy       = 1'b1;
            if (r_cnt == c_LAST) begin
               w_state_nxt = ST_FIN;
            end
         end
         ST_FIN: begin
            busy        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Montgomery step. With S < 2M and B < M, T < 3M and T + M < 4M, so
   // WIDTH+2 bits never overflow. Adding M when T is odd makes the sum even,
   // so the right shift is an exact division by two mod M.
   // ------------------------------------------------------------------------
   assign w_b_ext = {2'b00, r_b};
   assign w_m_ext = {2'b00, r_m};
   assign w_t     = r_s + (a_bit ? w_b_ext : '0);
   assign w_u     = w_t + (w_t[0] ? w_m_ext : '0);
   assign w_s_nxt = w_u >> 1;

   // Final conditional subtract brings S from [0, 2M) into [0, M).
   assign w_red   = (r_s >= w_m_ext) ? (r_s - w_m_ext) : r_s;

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s      <= '0;
         r_cnt    <= '0;
         r_b      <= '0;
         r_m      <= '0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_done <= (r_state == ST_FIN);
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_b   <= b_in;
                  r_m   <= m_in;
                  r_s   <= '0;
                  r_cnt <= '0;
               end
            end
            ST_RUN: begin
               r_s   <= w_s_nxt;
               r_cnt <= r_cnt + 1'b1;
            end
            ST_FIN: begin
               r_result <= WIDTH'(w_red);
            end
            default: begin
               r_s <= r_s;
            end
         endcase
      end
   end

   assign done   = r_done;
   assign result = r_result;

endmodule
`default_nettype wire
